// File: rtl/multdiv_pkg.sv
// Definitions shared by the multdiv path: divider FSM states and the common
// operand width and most-negative constant.
package multdiv_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it did not borrow.
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // diff MSB is the borrow: clear means rem >= divisor
    always_comb begin
        diff     = rem + ~{1'b0, divisor} + {{WIDTH{1'b0}}, 1'b1};
        q_bit    = ~diff[WIDTH];
        next_rem = q_bit ? diff[WIDTH-1:0] : rem[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: magnitudes are divided one bit per
// cycle, signs are applied afterwards, results are presented with a RDY pulse.
module seq_divider
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_quo_q, res_quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             res_exc_q, res_exc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exception_q, exception_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // quo_q starts as |A|; its MSB feeds the remainder while quotient bits fill from the bottom
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .rem      (rem_shift),
        .divisor  (divisor_q),
        .next_rem (step_rem),
        .q_bit    (step_bit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            ovf_q       <= 1'b0;
            res_quo_q   <= '0;
            res_rem_q   <= '0;
            res_exc_q   <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            ovf_q       <= ovf_d;
            res_quo_q   <= res_quo_d;
            res_rem_q   <= res_rem_d;
            res_exc_q   <= res_exc_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        ovf_d       = ovf_q;
        res_quo_d   = res_quo_q;
        res_rem_d   = res_rem_q;
        res_exc_d   = res_exc_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;

        // Publishing from DONE lets a new start overwrite res_* without disturbing the pulse
        if (state_q == S_DONE) begin
            rdy_d       = 1'b1;
            result_d    = res_quo_q;
            remainder_d = res_rem_q;
            exception_d = res_exc_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_DIV) begin
                    sign_a_d  = data_operandA[WIDTH-1];
                    sign_b_d  = data_operandB[WIDTH-1];
                    quo_d     = data_operandA[WIDTH-1] ? negate(data_operandA) : data_operandA;
                    divisor_d = data_operandB[WIDTH-1] ? negate(data_operandB) : data_operandB;
                    ovf_d     = (data_operandA == MIN_VAL) && (&data_operandB);
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (data_operandB == '0) begin
                        res_quo_d = '0;
                        res_rem_d = data_operandA;
                        res_exc_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // INT_MIN / -1 already yields INT_MIN here; only the exception flag is special
                res_quo_d = (sign_a_q ^ sign_b_q) ? negate(quo_q) : quo_q;
                res_rem_d = sign_a_q ? negate(rem_q) : rem_q;
                res_exc_d = ovf_q;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != S_IDLE) || rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider: expectations come from plain
// signed arithmetic and are matched against each RDY pulse by a monitor.
module tb_seq_divider;

    localparam int NORMAL_LAT = 34;
    localparam int ZERO_LAT   = 1;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        exc;
        int          rdy_edge;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int   errors = 0;
    int   checks = 0;
    int   edge_count = 0;
    exp_t scoreboard[$];
    exp_t mon_e;

    seq_divider #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_count++;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        r.rdy_edge = 0;
        if (b == 32'd0) begin
            r.quo = 32'd0;
            r.rem = a;
            r.exc = 1'b1;
        end else if (a == MIN32 && b == 32'hFFFF_FFFF) begin
            r.quo = MIN32;
            r.rem = 32'd0;
            r.exc = 1'b1;
        end else begin
            r.quo = sa / sb;
            r.rem = sa % sb;
            r.exc = 1'b0;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, expv, edge_count);
        end
    endtask

    // Called just after a negedge; the start is sampled on the following posedge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = refModel(a, b);
        e.rdy_edge = edge_count + 1 + ((b == 32'd0) ? ZERO_LAT : NORMAL_LAT);
        scoreboard.push_back(e);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (data_resultRDY !== 1'b1 && n < 60);
        if (data_resultRDY !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL rdy_timeout: got no RDY after %0d cycles expected RDY", n);
        end
    endtask

    task automatic runOne(input logic [31:0] a, input logic [31:0] b);
        applyStimulus(a, b);
        waitReady();
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_result"}, data_result, 32'd0);
        checkOutput({tag, "_remainder"}, data_remainder, 32'd0);
        checkOutput({tag, "_exception"}, {31'd0, data_exception}, 32'd0);
        checkOutput({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1 && data_resultRDY === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_rdy: got RDY at edge %0d expected none", edge_count);
            end else begin
                mon_e = scoreboard.pop_front();
                checkOutput("rdy_cycle", 32'(edge_count), 32'(mon_e.rdy_edge));
                checkOutput("result", data_result, mon_e.quo);
                checkOutput("remainder", data_remainder, mon_e.rem);
                checkOutput("exception", {31'd0, data_exception}, {31'd0, mon_e.exc});
                checkOutput("busy_at_rdy", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        checkCleared("reset");
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] directed cases");
        runOne(32'd100, 32'd7);
        runOne(-32'sd100, 32'd7);
        runOne(32'd100, -32'sd7);
        runOne(-32'sd100, -32'sd7);
        runOne(32'd5, 32'd0);
        runOne(MIN32, 32'hFFFF_FFFF);
        runOne(MIN32, 32'd2);

        // Start ignored while running, then a start during the RDY cycle
        applyStimulus(32'd1000, 32'd10);
        repeat (8) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        waitReady();
        runOne(32'd9, 32'd3);
        repeat (40) @(negedge clock);

        // Reset in the middle of a division abandons it
        applyStimulus(32'hFFFF_FFFF, 32'd1);
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        void'(scoreboard.pop_back());
        #1;
        checkCleared("midreset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        runOne(32'd7, 32'd2);

        $display("[TB] random cases");
        for (int i = 0; i < 1200; i++) begin
            case ($urandom_range(0, 7))
                0: b = 32'd1;
                1: b = 32'hFFFF_FFFF;
                2: b = (i % 4 == 0) ? 32'd0 : $urandom;
                3: b = $urandom_range(1, 20);
                4: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = MIN32;
                2: a = $urandom_range(0, 5);
                3: a = -$urandom_range(0, 5);
                default: a = $urandom;
            endcase
            runOne(a, b);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end

        repeat (40) @(negedge clock);
        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
